ps2kb_rx: RTL and testbench
===========================

// Module: ps2kb_rx
// PURPOSE
//  PS/2 keyboard receiver: the device end that feeds the 0xD address window of the memory-mapped IO bus.
//  - Deserialises 11-bit PS/2 frames from the keyboard and buffers scancodes in a small FIFO.
//  - Presents the FIFO head as ps2kb_key[9:0] for CPU reads.
//  - Pops one entry per CPU read strobe.
// PARAMETERS
//  FIFO_DEPTH   8      scancode entries; power of 2, >=2
//  TIMEOUT_CYC  50000  idle clk cycles mid-frame before abort (1 ms @ 50 MHz)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous reset, active-high
//  ps2_clk      in   1   raw PS/2 clock pin (asynchronous)
//  ps2_data     in   1   raw PS/2 data pin (asynchronous)
//  ps2kb_pop    in   1   one-cycle pulse; CPU read of the 0xD window completed
//  ps2kb_key    out  10  {valid, overflow, scancode[7:0]} of FIFO head
//  frame_err    out  1   one-cycle pulse when a frame is discarded
// BEHAVIOUR
//  Reset
//   - All outputs 0; FIFO empty; overflow clear; FSM in IDLE.
//   - Sync flops are preset to 1 (bus-idle level).
//   - Reset mid-frame discards the partial frame.
//  Input sync
//   - 2-flop synchronisers on ps2_clk and ps2_data.
//   - Falling edge = synced clk 1->0 versus the previous registered sample.
//   - Data is sampled on that same cycle.
//  FSM
//   - IDLE: on a falling edge with data==0 (start bit), go to SHIFT and clear bit_cnt. A falling edge with data==1 is ignored.
//   - SHIFT: every falling edge shifts data in LSB-first and increments bit_cnt. After 10 edges (8 data, parity, stop), go to CHECK.
//   - CHECK (1 cycle): the frame is good if stop==1 (and parity is correct, see CONFIGURATION). Good frame: push scancode. Bad frame: frame_err=1. Then return to IDLE.
//   - Timeout: a counter reloads on every falling edge. When it reaches TIMEOUT_CYC in SHIFT, pulse frame_err and return to IDLE.
//  Latency
//   - Stop-bit falling edge detected at cycle N.
//   - CHECK / push at N+1.
//   - ps2kb_key valid with the new byte at N+2 (if the FIFO was empty).
//  FIFO and output
//   - ps2kb_key[9] = ~empty.
//   - [8] = overflow flag.
//   - [7:0] = head entry; 0 when empty.
//   - Output is registered from FIFO state; there is no combinational path from ps2kb_pop.
//   - pop when empty: ignored.
//   - push when full: byte dropped, overflow set. overflow stays set until the next pop that actually dequeues, which clears it.
//   - push and pop in the same cycle when full: dequeue first, then the push succeeds; count and overflow are unchanged.
//   - push and pop in the same cycle when empty: the push lands; the pop is ignored.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  PS2KB_PARITY_CHECK_EN
//   - Defined: CHECK additionally requires odd parity over data+parity. A failing frame is dropped with a frame_err pulse.
//   - Undefined: the parity bit is shifted in and ignored; only start and stop bits are checked.
// STRUCTURE
//  - Package ps2kb_pkg holds:
//    - state encoding IDLE/SHIFT/CHECK
//    - FRAME_BITS=11
//    - key field offsets (KEY_VALID=9, KEY_OVF=8)
//  - Sub-module ps2kb_fifo is a synchronous FIFO with push/pop/full/empty, parameterised by FIFO_DEPTH.
//  - Sync, edge-detect and FSM stay in ps2kb_rx.
// TESTING
//  1. Send frame for 0x1C with good parity, FIFO empty -> ps2kb_key == 10'h21C two cycles after the stop edge; frame_err never pulses.
//  2. Send 0x1C, 0xF0, 0x1C, then pop three times -> heads read 0x1C, 0xF0, 0x1C in order; then ps2kb_key == 0.
//  3. Send FIFO_DEPTH+1 frames with no pops -> 9th byte dropped, key[8]=1; one pop -> key[8]=0 and head = 2nd byte.
//  4. Send frame with stop bit 0 -> one frame_err pulse; FIFO unchanged.
//  5. Send frame with bad parity -> with PS2KB_PARITY_CHECK_EN: frame_err pulse, no push; without it: byte pushed.
//  6. Stop ps2_clk after 5 bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM in IDLE; the next full frame is received correctly. Assert rst mid-frame -> all outputs 0 and the following frame decodes correctly.

Source files
------------

// File: rtl/ps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2kb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } ps2kb_state_t;

   localparam int FRAME_BITS = 11;
   localparam int KEY_VALID  = 9;
   localparam int KEY_OVF    = 8;

endpackage

// File: rtl/ps2kb_fifo.sv
// Synchronous scancode FIFO; head is read straight from storage at rd_ptr.
module ps2kb_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign dout  = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2kb_rx.sv
// PS/2 keyboard receiver: sync, frame FSM and scancode FIFO head for CPU reads.
// Optional odd-parity rejection is enabled by defining PS2KB_PARITY_CHECK_EN.
module ps2kb_rx
   import ps2kb_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       ps2kb_pop,
   output logic [9:0] ps2kb_key,
   output logic       frame_err
);

   localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 2);
   localparam logic [TW-1:0] TMO    = TW'(TIMEOUT_CYC);

   logic          clk_p0, clk_p1, clk_p2;
   logic          dat_p0, dat_p1;
   logic          fall;
   ps2kb_state_t  state;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;
   logic [TW-1:0] tmo_cnt;
   logic          push_q;
   logic          err_q;
   logic          good;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          do_pop;
   logic [7:0]    head;

   // Stage p0/p1: two-flop synchronisers; p2 holds the previous clock sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         clk_p2 <= 1'b1;
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
      end else begin
         clk_p0 <= ps2_clk;
         clk_p1 <= clk_p0;
         clk_p2 <= clk_p1;
         dat_p0 <= ps2_data;
         dat_p1 <= dat_p0;
      end
   end

   assign fall = clk_p2 & ~clk_p1;

   // Judged on the stop-bit edge: shreg holds data[7:0] and parity at that point.
`ifdef PS2KB_PARITY_CHECK_EN
   assign good = dat_p1 & (^shreg);
`else
   assign good = dat_p1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         tmo_cnt <= '0;
         push_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         push_q <= 1'b0;
         err_q  <= 1'b0;
         if (fall || state != SHIFT)
            tmo_cnt <= '0;
         else if (tmo_cnt != TMO)
            tmo_cnt <= tmo_cnt + TW'(1);
         case (state)
            IDLE: begin
               if (fall && !dat_p1) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (fall) begin
                  if (bit_cnt == LAST_BIT) begin
                     state  <= CHECK;
                     push_q <= good;
                     err_q  <= ~good;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (tmo_cnt == TMO) begin
                  state <= IDLE;
                  err_q <= 1'b1;
               end
            end
            CHECK:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == SHIFT && fall && bit_cnt != LAST_BIT)
         shreg <= {dat_p1, shreg[8:1]};
   end

   ps2kb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .pop   (ps2kb_pop),
      .din   (shreg[7:0]),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign do_pop = ps2kb_pop & ~empty;

   // A push into a full FIFO alongside a dequeue lands normally, so overflow is left alone.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (push_q && full && !do_pop)
         ovf <= 1'b1;
      else if (do_pop && !(push_q && full))
         ovf <= 1'b0;
   end

   always_comb begin
      ps2kb_key            = '0;
      ps2kb_key[KEY_VALID] = ~empty;
      ps2kb_key[KEY_OVF]   = ovf;
      ps2kb_key[7:0]       = empty ? 8'h00 : head;
   end

   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2kb_rx.sv
// Directed bench for ps2kb_rx: frame decode, FIFO order/overflow, errors, timeout, reset.
module tb_ps2kb_rx;

   localparam int DEPTH = 8;
   localparam int TMO   = 400;
   localparam int H     = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ps2kb_pop = 1'b0;
   logic [9:0] ps2kb_key;
   logic       frame_err;

   int n_chk = 0;
   int n_pass = 0;
   int err_cnt = 0;

   ps2kb_rx #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2kb_pop (ps2kb_pop),
      .ps2kb_key (ps2kb_key),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err)
         err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Ends right after the stop-bit falling edge is driven (on a negedge).
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic [10:0] fb;
      fb = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 10; i++)
         ps2_bit(fb[i]);
      ps2_data = fb[10];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
   endtask

   task automatic release_bus();
      repeat (H) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b0);
      release_bus();
   endtask

   task automatic send_partial(input logic [7:0] d, input int n);
      logic [10:0] fb;
      fb = {1'b1, ~^d, d, 1'b0};
      for (int i = 0; i < n; i++)
         ps2_bit(fb[i]);
      ps2_data = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic pop();
      @(negedge clk);
      ps2kb_pop = 1'b1;
      @(negedge clk);
      ps2kb_pop = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_key", ps2kb_key, 10'h000);
      check("reset_err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Test 1: latency of a single good frame
      send_frame(8'h1C, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("t1_n1_key", ps2kb_key, 10'h000);
      check("t1_n1_err", frame_err, 1'b0);
      @(posedge clk);
      #1 check("t1_n2_key", ps2kb_key, 10'h21C);
      release_bus();
      check("t1_errcnt", err_cnt, 0);
      pop();
      check("t1_popped", ps2kb_key, 10'h000);

      // Test 2: ordering
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
      check("t2_head0", ps2kb_key, 10'h21C);
      pop();
      check("t2_head1", ps2kb_key, 10'h2F0);
      pop();
      check("t2_head2", ps2kb_key, 10'h21C);
      pop();
      check("t2_empty", ps2kb_key, 10'h000);
      pop();
      check("t2_pop_empty", ps2kb_key, 10'h000);

      // Test 3: overflow, then simultaneous push/pop while full
      for (int i = 0; i < DEPTH; i++)
         send(8'(8'h10 + i));
      check("t3_full", ps2kb_key, 10'h210);
      send(8'h18);
      check("t3_ovf", ps2kb_key, 10'h310);
      pop();
      check("t3_ovf_clr", ps2kb_key, 10'h211);
      send(8'h19);
      check("t3_refull", ps2kb_key, 10'h211);
      send_frame(8'h1A, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 ps2kb_pop = 1'b1;
      @(posedge clk);
      #1 ps2kb_pop = 1'b0;
      check("t3_pushpop", ps2kb_key, 10'h212);
      release_bus();
      for (int i = 0; i < 6; i++) begin
         check("t3_drain", ps2kb_key, 10'(10'h212 + i));
         pop();
      end
      check("t3_drain_19", ps2kb_key, 10'h219);
      pop();
      check("t3_drain_1A", ps2kb_key, 10'h21A);
      pop();
      check("t3_drained", ps2kb_key, 10'h000);
      check("t3_errcnt", err_cnt, 0);

      // Test 4: bad stop bit
      send(8'h55);
      send_frame(8'h66, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1 check("t4_err_pulse", frame_err, 1'b1);
      @(posedge clk);
      #1 check("t4_err_end", frame_err, 1'b0);
      release_bus();
      check("t4_errcnt", err_cnt, 1);
      check("t4_fifo", ps2kb_key, 10'h255);

      // Test 5: bad parity
      send_frame(8'h77, 1'b1, 1'b0);
      release_bus();
`ifdef PS2KB_PARITY_CHECK_EN
      check("t5_errcnt", err_cnt, 2);
      pop();
      check("t5_after_pop", ps2kb_key, 10'h000);
`else
      check("t5_errcnt", err_cnt, 1);
      pop();
      check("t5_after_pop", ps2kb_key, 10'h277);
`endif
      pop();
      check("t5_empty", ps2kb_key, 10'h000);

      // Test 6: timeout mid-frame, then reset mid-frame
      err_cnt = 0;
      send_partial(8'hFF, 5);
      repeat (TMO + 50) @(negedge clk);
      check("t6_tmo_err", err_cnt, 1);
      send(8'h3A);
      check("t6_after_tmo", ps2kb_key, 10'h23A);
      send_partial(8'h4B, 6);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_rst_key", ps2kb_key, 10'h000);
      check("t6_rst_err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h4B);
      check("t6_after_rst", ps2kb_key, 10'h24B);
      check("t6_errcnt", err_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
